// File: rtl/bus_buf_pkg.sv
// ---------------------------------------------------------------------------
// bus_buf_pkg
// Shared definitions for the bidirectional bus buffer:
//   - occupancy states of each FIFO
//   - bit positions in the sticky error vector (used when BUS_BUF_ERR_EN is set)
//   - cnt_w(): width of an occupancy count able to hold the value DEPTH
// ---------------------------------------------------------------------------
package bus_buf_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY    = 2'd0,
        OCC_NONEMPTY = 2'd1,
        OCC_FULL     = 2'd2
    } occ_state_e;

    localparam int ERR_IN_OVF  = 0;
    localparam int ERR_IN_UNF  = 1;
    localparam int ERR_OUT_OVF = 2;
    localparam int ERR_OUT_UNF = 3;

    // A count must represent 0..DEPTH inclusive, hence one bit beyond the pointer.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/bus_buf_fifo.sv
// ---------------------------------------------------------------------------
// bus_buf_fifo
// Single-clock show-ahead FIFO used for each direction of the bus buffer.
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-low reset
//   i_push, i_din push request and data (dropped when full unless popping)
//   i_pop         pop request (ignored when empty)
//   o_head        head word, 0 while empty
//   o_full/o_empty/o_count  registered occupancy status
//   o_ovf/o_unf   single-cycle pulses for a dropped push / ignored pop
// Parameters: DATA_W data width, DEPTH entries (power of two, >= 2).
// ---------------------------------------------------------------------------
module bus_buf_fifo
    import bus_buf_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_push,
    input  logic                      i_pop,
    input  logic [DATA_W-1:0]         i_din,
    output logic [DATA_W-1:0]         o_head,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [cnt_w(DEPTH)-1:0]   o_count,
    output logic                      o_ovf,
    output logic                      o_unf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wrPtr;
    logic [AW-1:0]     r_rdPtr;
    logic [CW-1:0]     r_count;
    occ_state_e        r_state;
    occ_state_e        w_stateNext;
    logic [CW-1:0]     w_countNext;
    logic              w_empty;
    logic              w_full;
    logic              w_doPush;
    logic              w_doPop;

    assign w_empty = (r_state == OCC_EMPTY);
    assign w_full  = (r_state == OCC_FULL);

    // A pop frees a slot in the same edge, so a full FIFO still accepts a
    // push that coincides with a pop; an empty FIFO never pops.
    assign w_doPop  = i_pop & ~w_empty;
    assign w_doPush = i_push & (~w_full | w_doPop);

    assign o_ovf = i_push & ~w_doPush;
    assign o_unf = i_pop & w_empty;

    assign w_countNext = r_count + CW'(w_doPush) - CW'(w_doPop);

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_state <= OCC_EMPTY;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            r_count <= w_countNext;
            r_state <= w_stateNext;
        end
    end

    // Occupancy state follows the count that will be registered this edge,
    // so flags never depend combinationally on the strobes.
    always_comb begin
        w_stateNext = r_state;
        if (w_countNext == '0) begin
            w_stateNext = OCC_EMPTY;
        end else if (w_countNext == CW'(DEPTH)) begin
            w_stateNext = OCC_FULL;
        end else begin
            w_stateNext = OCC_NONEMPTY;
        end
    end

    assign o_head  = w_empty ? '0 : r_mem[r_rdPtr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule

// File: rtl/bus_buffer_fifo.sv
// ---------------------------------------------------------------------------
// bus_buffer_fifo
// Bidirectional data-bus buffer: an inbound FIFO (external -> internal) and
// an outbound FIFO (internal -> external). Tri-states stay outside; this
// block only exports data and output-enable signals.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   ext_din/ext_wr           external write into the inbound FIFO
//   ext_dout/ext_rd/ext_oe   external read from the outbound FIFO
//   int_din/int_wr           internal write into the outbound FIFO
//   int_dout/int_rd/int_oe   internal read from the inbound FIFO
//   in_/out_ full, empty, count   FIFO status
//   err[3:0], err_clr        sticky error flags (only with BUS_BUF_ERR_EN)
// Optional macro: BUS_BUF_ERR_EN adds the sticky error flags.
// Parameters: DATA_W bus width, DEPTH entries per FIFO.
// ---------------------------------------------------------------------------
module bus_buffer_fifo
    import bus_buf_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         ext_din,
    output logic [DATA_W-1:0]         ext_dout,
    output logic                      ext_oe,
    input  logic                      ext_wr,
    input  logic                      ext_rd,
    input  logic [DATA_W-1:0]         int_din,
    output logic [DATA_W-1:0]         int_dout,
    output logic                      int_oe,
    input  logic                      int_wr,
    input  logic                      int_rd,
    output logic                      in_full,
    output logic                      in_empty,
    output logic                      out_full,
    output logic                      out_empty,
    output logic [cnt_w(DEPTH)-1:0]   in_count,
`ifdef BUS_BUF_ERR_EN
    output logic [cnt_w(DEPTH)-1:0]   out_count,
    input  logic                      err_clr,
    output logic [3:0]                err
`else
    output logic [cnt_w(DEPTH)-1:0]   out_count
`endif
);

    logic       w_extCont;
    logic       w_intCont;
    logic       w_inPush;
    logic       w_inPop;
    logic       w_outPush;
    logic       w_outPop;
    logic       w_inOvf;
    logic       w_inUnf;
    logic       w_outOvf;
    logic       w_outUnf;
    logic [3:0] w_errSet;

    // Each side is half-duplex: a write and read together on one side is
    // contention and neither strobe reaches its FIFO.
    assign w_extCont = ext_wr & ext_rd;
    assign w_intCont = int_wr & int_rd;

    assign w_inPush  = ext_wr & ~ext_rd;
    assign w_inPop   = int_rd & ~int_wr;
    assign w_outPush = int_wr & ~int_rd;
    assign w_outPop  = ext_rd & ~ext_wr;

    bus_buf_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_inFifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_inPush),
        .i_pop   (w_inPop),
        .i_din   (ext_din),
        .o_head  (int_dout),
        .o_full  (in_full),
        .o_empty (in_empty),
        .o_count (in_count),
        .o_ovf   (w_inOvf),
        .o_unf   (w_inUnf)
    );

    bus_buf_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_outFifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_outPush),
        .i_pop   (w_outPop),
        .i_din   (int_din),
        .o_head  (ext_dout),
        .o_full  (out_full),
        .o_empty (out_empty),
        .o_count (out_count),
        .o_ovf   (w_outOvf),
        .o_unf   (w_outUnf)
    );

    // The enable is the pop condition itself, so the bus is only driven
    // while a word is really being handed over.
    assign int_oe = w_inPop & ~in_empty;
    assign ext_oe = w_outPop & ~out_empty;

    // Contention is reported on the underflow bit of the side it occurred on.
    always_comb begin
        w_errSet              = '0;
        w_errSet[ERR_IN_OVF]  = w_inOvf;
        w_errSet[ERR_IN_UNF]  = w_inUnf | w_intCont;
        w_errSet[ERR_OUT_OVF] = w_outOvf;
        w_errSet[ERR_OUT_UNF] = w_outUnf | w_extCont;
    end

`ifdef BUS_BUF_ERR_EN
    logic [3:0] r_err;

    // A new event in the clearing cycle survives the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= '0;
        end else begin
            r_err <= (err_clr ? 4'b0000 : r_err) | w_errSet;
        end
    end

    assign err = r_err;
`else
    logic w_unusedErrSet;
    assign w_unusedErrSet = ^w_errSet;
`endif

endmodule

// File: tb/tb_bus_buffer_fifo.sv
// ---------------------------------------------------------------------------
// tb_bus_buffer_fifo
// Scoreboard bench for bus_buffer_fifo. The reference model is a pair of
// bounded queues; accepted writes are pushed into them when stimulus is
// applied, and a monitor on the falling edge pops and compares whenever a
// word is being handed out. Covers BUS_BUF_ERR_EN when that macro is set.
// ---------------------------------------------------------------------------
module tb_bus_buffer_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] ext_din;
    logic [DATA_W-1:0] ext_dout;
    logic              ext_oe;
    logic              ext_wr;
    logic              ext_rd;
    logic [DATA_W-1:0] int_din;
    logic [DATA_W-1:0] int_dout;
    logic              int_oe;
    logic              int_wr;
    logic              int_rd;
    logic              in_full;
    logic              in_empty;
    logic              out_full;
    logic              out_empty;
    logic [CW-1:0]     in_count;
    logic [CW-1:0]     out_count;
`ifdef BUS_BUF_ERR_EN
    logic              err_clr;
    logic [3:0]        err;
    logic [3:0]        expErr;
`endif

    int compared   = 0;
    int mismatched = 0;

    logic [DATA_W-1:0] refIn[$];
    logic [DATA_W-1:0] refOut[$];
    int inSizeAtSample  = 0;
    int outSizeAtSample = 0;

    bus_buffer_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ext_din   (ext_din),
        .ext_dout  (ext_dout),
        .ext_oe    (ext_oe),
        .ext_wr    (ext_wr),
        .ext_rd    (ext_rd),
        .int_din   (int_din),
        .int_dout  (int_dout),
        .int_oe    (int_oe),
        .int_wr    (int_wr),
        .int_rd    (int_rd),
        .in_full   (in_full),
        .in_empty  (in_empty),
        .out_full  (out_full),
        .out_empty (out_empty),
        .in_count  (in_count),
`ifdef BUS_BUF_ERR_EN
        .out_count (out_count),
        .err_clr   (err_clr),
        .err       (err)
`else
        .out_count (out_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of strobes, then at the rising edge advance the model.
    // The monitor has already popped any word handed out this cycle.
    task automatic applyStimulus(input logic ew, input logic er, input logic iw, input logic ir,
                                 input logic [DATA_W-1:0] ed, input logic [DATA_W-1:0] idn,
                                 input logic clr);
        bit inPush, outPush, inOvf, outOvf, inUnf, outUnf;
        ext_wr  = ew;
        ext_rd  = er;
        int_wr  = iw;
        int_rd  = ir;
        ext_din = ed;
        int_din = idn;
`ifdef BUS_BUF_ERR_EN
        err_clr = clr;
`endif
        @(posedge clk);
        if (rst) begin
            inPush  = ew && !er;
            outPush = iw && !ir;
            inOvf   = inPush && refIn.size() >= DEPTH;
            outOvf  = outPush && refOut.size() >= DEPTH;
            inUnf   = ir && !iw && inSizeAtSample == 0;
            outUnf  = er && !ew && outSizeAtSample == 0;
            if (inPush && !inOvf) refIn.push_back(ed);
            if (outPush && !outOvf) refOut.push_back(idn);
`ifdef BUS_BUF_ERR_EN
            expErr = (clr ? 4'b0000 : expErr) |
                     {outUnf || (ew && er), outOvf, inUnf || (iw && ir), inOvf};
`else
            if (clr && (inUnf || outUnf)) begin end
`endif
        end
        #1;
    endtask

    // Monitor: status is checked against the model every cycle; when the model
    // says a word is presented, the scoreboard entry is popped and compared.
    always @(negedge clk) begin
        bit expIntOe, expExtOe;
        logic [DATA_W-1:0] expInHead, expOutHead;
        inSizeAtSample  = refIn.size();
        outSizeAtSample = refOut.size();
        checkOutput("in_count",  32'(in_count),  32'(refIn.size()));
        checkOutput("out_count", 32'(out_count), 32'(refOut.size()));
        checkOutput("in_empty",  32'(in_empty),  32'(refIn.size() == 0));
        checkOutput("in_full",   32'(in_full),   32'(refIn.size() == DEPTH));
        checkOutput("out_empty", 32'(out_empty), 32'(refOut.size() == 0));
        checkOutput("out_full",  32'(out_full),  32'(refOut.size() == DEPTH));
        expIntOe   = rst && int_rd && !int_wr && refIn.size() > 0;
        expExtOe   = rst && ext_rd && !ext_wr && refOut.size() > 0;
        expInHead  = (refIn.size() > 0) ? refIn[0] : '0;
        expOutHead = (refOut.size() > 0) ? refOut[0] : '0;
        checkOutput("int_oe", 32'(int_oe), 32'(expIntOe));
        checkOutput("ext_oe", 32'(ext_oe), 32'(expExtOe));
        if (expIntOe) begin
            checkOutput("int_dout_word", 32'(int_dout), 32'(refIn.pop_front()));
        end else begin
            checkOutput("int_dout_idle", 32'(int_dout), 32'(expInHead));
        end
        if (expExtOe) begin
            checkOutput("ext_dout_word", 32'(ext_dout), 32'(refOut.pop_front()));
        end else begin
            checkOutput("ext_dout_idle", 32'(ext_dout), 32'(expOutHead));
        end
`ifdef BUS_BUF_ERR_EN
        checkOutput("err", 32'(err), 32'(expErr));
`endif
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 8'h00, 8'h00, 0);
    endtask

    initial begin
        rst     = 1'b0;
        ext_wr  = 0; ext_rd = 0; int_wr = 0; int_rd = 0;
        ext_din = '0; int_din = '0;
`ifdef BUS_BUF_ERR_EN
        err_clr = 0;
        expErr  = '0;
`endif
        #2;
        checkOutput("reset_in_empty",  32'(in_empty),  32'd1);
        checkOutput("reset_out_empty", 32'(out_empty), 32'd1);
        checkOutput("reset_in_count",  32'(in_count),  32'd0);
        checkOutput("reset_out_count", 32'(out_count), 32'd0);
        checkOutput("reset_int_oe",    32'(int_oe),    32'd0);
        checkOutput("reset_ext_oe",    32'(ext_oe),    32'd0);
        checkOutput("reset_int_dout",  32'(int_dout),  32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] external writes, internal reads");
        applyStimulus(1, 0, 0, 0, 8'h11, 8'h00, 0);
        applyStimulus(1, 0, 0, 0, 8'h22, 8'h00, 0);
        applyStimulus(1, 0, 0, 0, 8'h33, 8'h00, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 8'h00, 8'h00, 0);
        idle(1);

        $display("[TB] outbound overflow");
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0, 8'h00, 8'(8'hA0 + i), 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0, 8'h00, 8'h00, 0);
        applyStimulus(0, 0, 0, 0, 8'h00, 8'h00, 1);

        $display("[TB] push and pop while full");
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0, 8'(8'h61 + i), 8'h00, 0);
        applyStimulus(1, 0, 0, 1, 8'h55, 8'h00, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 8'h00, 8'h00, 0);
        applyStimulus(0, 0, 0, 0, 8'h00, 8'h00, 1);

        $display("[TB] internal contention");
        applyStimulus(1, 0, 0, 0, 8'h71, 8'h00, 0);
        applyStimulus(1, 0, 0, 0, 8'h72, 8'h00, 0);
        applyStimulus(0, 0, 1, 1, 8'h00, 8'h99, 0);
        idle(1);
        applyStimulus(0, 0, 0, 0, 8'h00, 8'h00, 1);
        idle(1);

        $display("[TB] asynchronous reset mid-cycle");
        applyStimulus(1, 0, 0, 0, 8'h81, 8'h00, 0);
        applyStimulus(0, 0, 1, 0, 8'h00, 8'h82, 0);
        #2;
        int_rd = 1'b1;
        rst    = 1'b0;
        refIn.delete();
        refOut.delete();
`ifdef BUS_BUF_ERR_EN
        expErr = '0;
`endif
        #1;
        checkOutput("async_in_empty",  32'(in_empty),  32'd1);
        checkOutput("async_in_count",  32'(in_count),  32'd0);
        checkOutput("async_out_count", 32'(out_count), 32'd0);
        checkOutput("async_int_oe",    32'(int_oe),    32'd0);
        checkOutput("async_int_dout",  32'(int_dout),  32'd0);
        int_rd = 1'b0;
        ext_wr = 1'b0;
        int_wr = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 0, 0, 0, 8'(8'hC0 + i), 8'h00, 0);
            applyStimulus(0, 0, 0, 1, 8'h00, 8'h00, 0);
        end

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 40,
                          $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 40,
                          8'($urandom), 8'($urandom), $urandom_range(0, 99) < 10);
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
